// File: rtl/mm_tile_loader.sv
`default_nettype none
// ============================================================================
// Module      : mm_tile_loader
// Description : Fetches one operand tile from host memory over an in-order
//               request/response port and scatters its elements into the T
//               bank write ports of the systolic array (row- or col-major).
// Revision    : 1.0 - initial release
// ============================================================================
module mm_tile_loader #(
    parameter int W         = 16,
    parameter int T         = 4,
    parameter int HOST_DW   = 64,
    parameter int AW        = 10,
    parameter int MAX_OUTST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic [31:0]          base_addr,
    input  logic [15:0]          ld,
    input  logic [15:0]          tile_rows,
    input  logic [15:0]          tile_cols,
    input  logic [15:0]          tile_len_k,
    input  logic                 bankset_sel,
    input  logic                 col_major_mode,
    output logic                 mem_rd_req,
    output logic [31:0]          mem_rd_addr,
    input  logic                 mem_rd_gnt,
    input  logic                 mem_rd_rvalid,
    input  logic [HOST_DW-1:0]   mem_rd_rdata,
    output logic [T-1:0]         bank_wr_en,
    output logic [T*AW-1:0]      bank_wr_addr,
    output logic [T*W-1:0]       bank_wr_data
);

    localparam int c_epb        = HOST_DW / W;
    localparam int c_beat_bytes = HOST_DW / 8;
    localparam int c_elem_bytes = W / 8;
    localparam int c_iw         = (c_epb > 1) ? $clog2(c_epb) : 1;
    localparam int c_pw         = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int c_cw         = c_pw + 1;
    localparam int c_bw         = (T > 1) ? $clog2(T) : 1;

    localparam logic [16:0]     c_epb_m1    = 17'(c_epb - 1);
    localparam logic [16:0]     c_epb17     = 17'(c_epb);
    localparam logic [c_iw-1:0] c_last_idx  = c_iw'(c_epb - 1);
    localparam logic [c_cw:0]   c_credit    = (c_cw + 1)'(MAX_OUTST);
    localparam logic [c_cw-1:0] c_fifo_full = c_cw'(MAX_OUTST);
    localparam logic [T-1:0]    c_one_hot0  = T'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;

    // Parameters captured on the accepted start
    logic [31:0] r_stride;
    logic [15:0] r_lines;
    logic [15:0] r_epl;
    logic [15:0] r_bpl;
    logic        r_bankset;
    logic        r_colmaj;

    // Issue side
    logic [15:0] r_iss_line;
    logic [15:0] r_iss_beat;
    logic [31:0] r_line_addr;
    logic [31:0] r_req_addr;
    logic        r_iss_done;

    // Response FIFO and credit tracking
    logic [HOST_DW-1:0] r_fifo [MAX_OUTST];
    logic [c_pw-1:0]    r_wp;
    logic [c_pw-1:0]    r_rp;
    logic [c_cw-1:0]    r_cnt;
    logic [c_cw-1:0]    r_outst;

    // Unpack side
    logic [15:0]     r_up_line;
    logic [15:0]     r_up_e;
    logic [c_iw-1:0] r_up_idx;

    // Geometry derived from the live inputs, only used at start
    logic [15:0] w_lines;
    logic [15:0] w_epl;
    logic [16:0] w_bpl_sum;
    logic [15:0] w_bpl;
    logic [31:0] w_stride;
    logic        w_start_ok;
    logic        w_empty_tile;

    assign w_lines      = col_major_mode ? tile_len_k : tile_rows;
    assign w_epl        = col_major_mode ? tile_cols  : tile_len_k;
    assign w_bpl_sum    = {1'b0, w_epl} + c_epb_m1;
    assign w_bpl        = 16'(w_bpl_sum / c_epb17);
    assign w_stride     = {16'd0, ld} * 32'(c_elem_bytes);
    assign w_start_ok   = (r_state == S_IDLE) && start;
    assign w_empty_tile = (w_lines == 16'd0) || (w_epl == 16'd0);

    logic w_credit_ok;
    logic w_gnt;
    logic w_push;
    logic w_avail;
    logic w_line_end;
    logic w_beat_end;
    logic w_tile_end;
    logic w_pop;

    // Credits count both in-flight requests and beats parked in the FIFO,
    // so a response always finds a free slot.
    assign w_credit_ok = ({1'b0, r_outst} + {1'b0, r_cnt}) < c_credit;
    assign mem_rd_req  = (r_state == S_RUN) && !r_iss_done && w_credit_ok;
    assign mem_rd_addr = r_req_addr;
    assign w_gnt       = mem_rd_req && mem_rd_gnt;
    // Responses with no matching request (left over from before a reset) are dropped.
    assign w_push      = mem_rd_rvalid && (r_outst != '0);
    assign w_avail     = (r_state == S_RUN) && (r_cnt != '0);
    assign w_line_end  = (r_up_e == r_epl - 16'd1);
    assign w_beat_end  = (r_up_idx == c_last_idx) || w_line_end;
    assign w_tile_end  = w_line_end && (r_up_line == r_lines - 16'd1);
    assign w_pop       = w_avail && w_beat_end;

    // Head beat viewed as an array of elements
    logic [HOST_DW-1:0] w_head;
    logic [W-1:0]       w_head_elems [c_epb];
    assign w_head = r_fifo[r_rp];

    genvar gi;
    generate
        for (gi = 0; gi < c_epb; gi++) begin : g_head
            assign w_head_elems[gi] = w_head[gi*W +: W];
        end
    endgenerate

    logic [W-1:0]    w_elem;
    logic [c_bw-1:0] w_bank;
    logic [15:0]     w_idx;
    logic [AW-1:0]   w_waddr;

    assign w_elem  = w_head_elems[r_up_idx];
    assign w_bank  = r_colmaj ? r_up_e[c_bw-1:0] : r_up_line[c_bw-1:0];
    assign w_idx   = r_colmaj ? r_up_line : r_up_e;
    assign w_waddr = {r_bankset, w_idx[AW-2:0]};

    // Control FSM: latches parameters, sequences busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            r_stride  <= '0;
            r_lines   <= '0;
            r_epl     <= '0;
            r_bpl     <= '0;
            r_bankset <= 1'b0;
            r_colmaj  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_stride  <= w_stride;
                        r_lines   <= w_lines;
                        r_epl     <= w_epl;
                        r_bpl     <= w_bpl;
                        r_bankset <= bankset_sel;
                        r_colmaj  <= col_major_mode;
                        busy      <= 1'b1;
                        r_state   <= w_empty_tile ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_avail && w_tile_end) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Request address generator: walks beats within a line, then lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_line  <= '0;
            r_iss_beat  <= '0;
            r_line_addr <= '0;
            r_req_addr  <= '0;
            r_iss_done  <= 1'b0;
        end else if (w_start_ok) begin
            r_iss_line  <= '0;
            r_iss_beat  <= '0;
            r_line_addr <= base_addr;
            r_req_addr  <= base_addr;
            r_iss_done  <= w_empty_tile;
        end else if (w_gnt) begin
            if (r_iss_beat == r_bpl - 16'd1) begin
                r_iss_beat  <= '0;
                r_iss_line  <= r_iss_line + 16'd1;
                r_line_addr <= r_line_addr + r_stride;
                r_req_addr  <= r_line_addr + r_stride;
                if (r_iss_line == r_lines - 16'd1) begin
                    r_iss_done <= 1'b1;
                end
            end else begin
                r_iss_beat <= r_iss_beat + 16'd1;
                r_req_addr <= r_req_addr + 32'(c_beat_bytes);
            end
        end
    end

    // Response FIFO storage, pointers, occupancy and outstanding-request count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                r_fifo[i] <= '0;
            end
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_outst <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wp] <= mem_rd_rdata;
                r_wp         <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            case ({w_gnt, w_push})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    // Unpacker: one element per cycle from the FIFO head into a registered bank write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up_line    <= '0;
            r_up_e       <= '0;
            r_up_idx     <= '0;
            bank_wr_en   <= '0;
            bank_wr_addr <= '0;
            bank_wr_data <= '0;
        end else begin
            bank_wr_en <= '0;
            if (w_start_ok) begin
                r_up_line <= '0;
                r_up_e    <= '0;
                r_up_idx  <= '0;
            end else if (w_avail) begin
                bank_wr_en   <= c_one_hot0 << w_bank;
                bank_wr_addr <= {T{w_waddr}};
                bank_wr_data <= {T{w_elem}};
                if (w_line_end) begin
                    r_up_line <= r_up_line + 16'd1;
                    r_up_e    <= '0;
                    r_up_idx  <= '0;
                end else if (w_beat_end) begin
                    r_up_e   <= r_up_e + 16'd1;
                    r_up_idx <= '0;
                end else begin
                    r_up_e   <= r_up_e + 16'd1;
                    r_up_idx <= r_up_idx + 1'b1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // A push into a full FIFO without a simultaneous pop means the credit rule broke
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_push && !w_pop && (r_cnt == c_fifo_full)));
        end
    end
`endif

endmodule
`default_nettype wire
